// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, ALU operation enum and register-index width
package mips_pkg;
  localparam int REG_W = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
endpackage

// File: rtl/mips_alu.sv
// mips_alu: 32-bit combinational ALU for the single-cycle MIPS core
// Ports: a, b operands; op operation select; result 32-bit output; zero high when result is 0
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);
  always_comb
    result = op == ALU_ADD ? a + b :
             op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b :
             op == ALU_OR  ? a | b :
             {31'd0, $signed(a) < $signed(b)};
  assign zero = result == '0;
endmodule

// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle MIPS subset core (add/sub/and/or/slt/addi/slti/lw/sw/beq/j)
// Ports: rst async active-low reset; clk; inst_adr/inst instruction fetch; data_adr/data_out/data_in
// data memory address, read data and store data; mem_read/mem_write load and store strobes.
// Define MIPS_JAL_JR_EN to add jal and jr; otherwise they execute as NOPs.
module mips_single_cycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        rst,
  input  logic        clk,
  output logic [31:0] inst_adr,
  input  logic [31:0] inst,
  output logic [31:0] data_adr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        mem_read,
  output logic        mem_write
);
  logic [31:0]      pc_q, pc_d, pc_plus4, imm_sext, rs_val, rt_val, alu_b, alu_res, wr_data;
  logic [31:0]      rf_q [32];
  logic [5:0]       opcode, funct;
  logic [REG_W-1:0] rs, rt, rd, wr_sel;
  logic             reg_we, use_imm, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, zero;
  alu_op_e          alu_op;
  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  always_comb begin
    reg_we  = 1'b0;
    wr_sel  = rt;
    use_imm = 1'b0;
    alu_op  = ALU_ADD;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE:
        case (funct)
          F_ADD: begin reg_we = 1'b1; wr_sel = rd; alu_op = ALU_ADD; end
          F_SUB: begin reg_we = 1'b1; wr_sel = rd; alu_op = ALU_SUB; end
          F_AND: begin reg_we = 1'b1; wr_sel = rd; alu_op = ALU_AND; end
          F_OR:  begin reg_we = 1'b1; wr_sel = rd; alu_op = ALU_OR;  end
          F_SLT: begin reg_we = 1'b1; wr_sel = rd; alu_op = ALU_SLT; end
`ifdef MIPS_JAL_JR_EN
          F_JR:  is_jr = 1'b1;
`endif
          default: ;
        endcase
      OP_ADDI: begin reg_we = 1'b1; use_imm = 1'b1; end
      OP_SLTI: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      OP_LW:   begin reg_we = 1'b1; use_imm = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; is_sw = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; is_beq = 1'b1; end
      OP_J:    is_j = 1'b1;
`ifdef MIPS_JAL_JR_EN
      OP_JAL:  begin reg_we = 1'b1; wr_sel = 5'd31; is_jal = 1'b1; end
`endif
      default: ;
    endcase
  end
  assign rs_val = rs == '0 ? '0 : rf_q[rs];
  assign rt_val = rt == '0 ? '0 : rf_q[rt];
  assign alu_b  = use_imm ? imm_sext : rt_val;
  mips_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (zero)
  );
  assign pc_plus4 = pc_q + 32'd4;
  assign wr_data  = is_lw ? data_out : is_jal ? pc_plus4 : alu_res;
  assign pc_d     = is_jr ? rs_val :
                    (is_j | is_jal) ? {pc_plus4[31:28], inst[25:0], 2'b00} :
                    (is_beq & zero) ? pc_plus4 + {imm_sext[29:0], 2'b00} :
                    pc_plus4;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (reg_we && wr_sel != '0) rf_q[wr_sel] <= wr_data;
  assign inst_adr  = pc_q;
  assign data_adr  = alu_res;
  assign data_in   = rt_val;
  // strobes are gated by reset so an in-flight store is dropped the moment reset asserts
  assign mem_read  = rst & is_lw;
  assign mem_write = rst & is_sw;
endmodule

// File: tb/tb_mips_single_cycle.sv
// tb_mips_single_cycle: directed programs with hand-computed memory contents and PC traces
module tb_mips_single_cycle;
  logic        rst, clk;
  logic [31:0] inst_adr, inst, data_adr, data_out, data_in;
  logic        mem_read, mem_write;
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          n_chk = 0, n_fail = 0;
  mips_single_cycle dut (
    .rst       (rst),
    .clk       (clk),
    .inst_adr  (inst_adr),
    .inst      (inst),
    .data_adr  (data_adr),
    .data_out  (data_out),
    .data_in   (data_in),
    .mem_read  (mem_read),
    .mem_write (mem_write)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign inst     = imem[inst_adr[7:2]];
  assign data_out = dmem[data_adr[7:2]];
  always @(posedge clk) if (mem_write) dmem[data_adr[7:2]] <= data_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] r_op(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction
  function automatic logic [31:0] j_op(input logic [5:0] o, input logic [25:0] tg);
    return {o, tg};
  endfunction
  task automatic begin_prog();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'h0;
      dmem[i] <= 32'h0;
    end
  endtask
  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  logic [31:0] tr3 [7] = '{32'd0, 32'd4, 32'd8, 32'd16, 32'd20, 32'd40, 32'd44};
`ifdef MIPS_JAL_JR_EN
  logic [31:0] tr6 [6] = '{32'd0, 32'd4, 32'd32, 32'd36, 32'd8, 32'd12};
  logic [31:0] exp6 = 32'd2;
`else
  logic [31:0] tr6 [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
  logic [31:0] exp6 = 32'd1;
`endif
  initial begin
    rst = 1'b0;
    // slti signed compare: -5 < 3 true, -5 < -6 false
    begin_prog();
    imem[0] = i_op(6'h08, 0, 1, 16'hFFFB);
    imem[1] = i_op(6'h0A, 1, 2, 16'd3);
    imem[2] = i_op(6'h0A, 1, 3, 16'hFFFA);
    imem[3] = i_op(6'h2B, 0, 2, 16'd0);
    imem[4] = i_op(6'h2B, 0, 3, 16'd4);
    dmem[1] <= 32'hDEAD;
    #1;
    chk("rst_pc", inst_adr, 32'h0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    go();
    step(5);
    chk("slti_true", dmem[0], 32'd1);
    chk("slti_false", dmem[1], 32'd0);
    chk("pc_after5", inst_adr, 32'd20);
    // load/store round trip; mem_read only in the lw cycle
    begin_prog();
    imem[0] = i_op(6'h08, 0, 1, 16'h0055);
    imem[1] = i_op(6'h2B, 0, 1, 16'd8);
    imem[2] = i_op(6'h23, 0, 4, 16'd8);
    imem[3] = r_op(6'h20, 4, 4, 5);
    imem[4] = i_op(6'h2B, 0, 5, 16'd12);
    go();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mem_read_%0d", k), {31'd0, mem_read}, {31'd0, k == 2});
      if (k == 2) chk("lw_adr", data_adr, 32'd8);
      step(1);
    end
    chk("lw_add_sw", dmem[3], 32'hAA);
    // beq taken skips, beq not taken falls through, j lands at target
    begin_prog();
    imem[0]  = i_op(6'h08, 0, 1, 16'd3);
    imem[1]  = i_op(6'h08, 0, 2, 16'd3);
    imem[2]  = i_op(6'h04, 1, 2, 16'd1);
    imem[3]  = i_op(6'h08, 0, 3, 16'd1);
    imem[4]  = i_op(6'h04, 1, 0, 16'd5);
    imem[5]  = j_op(6'h02, 26'd10);
    imem[10] = i_op(6'h2B, 0, 3, 16'd20);
    dmem[5] <= 32'hFF;
    go();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("br_trace_%0d", k), inst_adr, tr3[k]);
      step(1);
    end
    chk("skipped_write", dmem[5], 32'd0);
    // writes to $0 are ignored
    begin_prog();
    imem[0] = i_op(6'h08, 0, 0, 16'd7);
    imem[1] = i_op(6'h2B, 0, 0, 16'd16);
    dmem[4] <= 32'h1234;
    go();
    step(2);
    chk("r0_zero", dmem[4], 32'd0);
    // 3 ns reset pulse while a store is pending
    begin_prog();
    imem[0] = i_op(6'h08, 0, 1, 16'd9);
    imem[1] = i_op(6'h08, 0, 2, 16'd2);
    imem[2] = i_op(6'h2B, 0, 1, 16'd24);
    dmem[6] <= 32'h77;
    go();
    step(2);
    chk("pre_rst_we", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_pc", inst_adr, 32'h0);
    chk("mid_rst_we", {31'd0, mem_write}, 32'd0);
    chk("mid_rst_re", {31'd0, mem_read}, 32'd0);
    chk("mid_rst_regs", data_in, 32'd0);
    #2 rst = 1'b1;
    step(1);
    chk("no_write_in_rst", dmem[6], 32'h77);
    chk("resume_pc", inst_adr, 32'd4);
    step(2);
    chk("resume_sw", dmem[6], 32'd9);
    // jal/jr subroutine call, or both as NOPs when the feature is off
    begin_prog();
    imem[0] = i_op(6'h08, 0, 1, 16'd1);
    imem[1] = j_op(6'h03, 26'd8);
    imem[2] = i_op(6'h2B, 0, 1, 16'd28);
    imem[3] = r_op(6'h08, 31, 0, 0);
    imem[8] = i_op(6'h08, 0, 1, 16'd2);
    imem[9] = r_op(6'h08, 31, 0, 0);
    go();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("jal_trace_%0d", k), inst_adr, tr6[k]);
      step(1);
    end
    chk("jal_ret_sw", dmem[7], exp6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_single_cycle.md
MIPS_SINGLE_CYCLE -- requirements
Module: mips_single_cycle

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address loaded into the PC on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port inst_adr, output, 32 bits: byte address of the current instruction, equal to the PC.
REQ-005 The block SHALL have port inst, input, 32 bits: instruction word returned combinationally by instruction memory.
REQ-006 The block SHALL have port data_adr, output, 32 bits: data memory byte address, equal to the ALU result.
REQ-007 The block SHALL have port data_out, input, 32 bits: read data from data memory (memory-side naming).
REQ-008 The block SHALL have port data_in, output, 32 bits: store data to data memory, equal to register rt.
REQ-009 The block SHALL have ports mem_read and mem_write, outputs, 1 bit each: load and store strobes.
REQ-010 Port order SHALL be rst, clk, inst_adr, inst, data_adr, data_out, data_in, mem_read, mem_write.

Function
REQ-011 The block SHALL execute one instruction per clock cycle; all decode, ALU and memory paths are combinational; the PC and register file update on the rising clk edge.
REQ-012 The block SHALL support add, sub, and, or and slt (R-type, opcode 0, funct 0x20, 0x22, 0x24, 0x25, 0x2A), plus addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04 and j 0x02.
REQ-013 Register file SHALL be 32x32 with two combinational read ports and one write port; $0 SHALL read 0 always and writes to it SHALL be ignored.
REQ-014 Immediates for addi, slti, lw, sw and beq SHALL be sign-extended to 32 bits; arithmetic SHALL be 32-bit two's complement with overflow ignored.
REQ-015 slt and slti SHALL write 1 if the signed first operand is less than the signed second operand, else 0.
REQ-016 mem_read SHALL be 1 only for lw and mem_write only for sw; memory writes SHALL occur on the rising edge while mem_write=1.
REQ-017 The next PC SHALL be PC+4 by default; for beq with rs==rt it SHALL be PC+4+(sext(imm)<<2); for j it SHALL be {PC+4[31:28], target26, 2'b00}.
REQ-018 Unrecognised opcodes or funct codes SHALL execute as a NOP: no register write, no memory strobe, PC+4.
REQ-019 The PC SHALL wrap modulo 2^32 without error.

Reset
REQ-020 While rst=0, PC SHALL equal RESET_PC, all registers SHALL read 0, and mem_read and mem_write SHALL both be 0.
REQ-021 Reset assertion mid-instruction SHALL take effect immediately and SHALL suppress any pending write; execution SHALL resume at RESET_PC on the first rising edge after rst returns to 1.

Configuration
REQ-022 With macro MIPS_JAL_JR_EN defined, the block SHALL support jal (opcode 0x03: $31 := PC+4, jump as j) and jr (R-type funct 0x08: PC := rs).
REQ-023 Without MIPS_JAL_JR_EN, jal and jr SHALL decode as NOPs per REQ-018.

Structure
REQ-024 A shared package mips_pkg SHALL hold the opcode and funct constants, the ALU-operation enum typedef and the register-index width.
REQ-025 The ALU SHALL be one sub-module, mips_alu, with inputs a, b and op, and outputs result and zero.
REQ-026 Decoder, register file and PC logic SHALL reside in mips_single_cycle.

Verification
REQ-027 Test: addi $1,$0,-5; slti $2,$1,3; slti $3,$1,-6; sw $2,0($0); sw $3,4($0) -> mem[0]=1 and mem[4]=0.
REQ-028 Test: addi $1,$0,0x55; sw $1,8($0); lw $4,8($0); add $5,$4,$4; sw $5,12($0) -> mem[12]=0xAA, and mem_read=1 exactly in the lw cycle.
REQ-029 Test: beq taken (rs==rt) skips the next instruction; beq not taken falls through; j lands at the target -> PC trace on inst_adr matches.
REQ-030 Test: addi $0,$0,7; sw $0,16($0) -> mem[16]=0.
REQ-031 Test: rst driven to 0 for 3 ns mid-program -> inst_adr=0 immediately, and no memory write occurs in that cycle.
REQ-032 Test: with MIPS_JAL_JR_EN defined, jal to a subroutine that executes jr $31 -> execution returns to the jal address+4.
